// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, mid-bit sampling.
//
// The serial line is brought into the clock domain through a two-flop
// synchronizer; every decision uses the second flop (rx_s). A falling edge
// seen in IDLE is confirmed half a bit later, then each data bit and the stop
// bit are sampled one full bit period apart. After the stop sample the
// receiver waits in CLEANUP for the line to go high, so a held-low break can
// never be mistaken for a new start bit.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (legal 4..16383)
//
// Ports
//   i_Clock      in   1  sole clock, rising edge
//   i_Reset      in   1  synchronous active-high reset
//   i_Rx_Serial  in   1  asynchronous serial line, idle high
//   o_Rx_DV      out  1  one-cycle pulse, o_Rx_Byte valid in that cycle
//   o_Rx_Byte    out  8  last correctly framed byte, held until the next one
//   o_Rx_Active  out  1  high from confirmed start bit until back in idle
//   o_Frame_Err  out  1  one-cycle pulse when the stop bit samples low
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Frame_Err
);

   // Terminal counts: the last cycle of a full bit, and the middle of the
   // start bit (integer division, so odd and even bit lengths both work).
   localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
   localparam logic [13:0] HALF_LAST = 14'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } state_t;

   state_t      state_reg, state_next;

   logic [1:0]  sync_reg;
   logic        rx_s;

   logic [13:0] cnt_reg, cnt_next;
   logic [2:0]  idx_reg, idx_next;
   logic [7:0]  shift_reg, shift_next;

   logic        dv_reg, dv_next;
   logic        err_reg, err_next;
   logic        active_reg, active_next;
   logic [7:0]  byte_reg, byte_next;

   logic        half_done;
   logic        bit_done;
   logic        data_load;

   // ------------------------------------------------------------------
   // Input synchronizer. Resets to the idle (high) level so that a reset
   // never manufactures a falling edge on its own.
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], i_Rx_Serial};
      end
   end

   assign rx_s = sync_reg[1];

   assign half_done = (cnt_reg == HALF_LAST);
   assign bit_done  = (cnt_reg == BIT_LAST);

   // ------------------------------------------------------------------
   // Process 1: state and datapath registers.
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         dv_reg     <= 1'b0;
         err_reg    <= 1'b0;
         active_reg <= 1'b0;
         byte_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         shift_reg  <= shift_next;
         dv_reg     <= dv_next;
         err_reg    <= err_next;
         active_reg <= active_next;
         byte_reg   <= byte_next;
      end
   end

   // ------------------------------------------------------------------
   // Process 2: next state, bit-timing counter and bit index.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      data_load  = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end

         START: begin
            if (half_done) begin
               cnt_next = '0;
               // Line back high by mid start bit: it was a glitch.
               state_next = rx_s ? IDLE : DATA;
            end else begin
               cnt_next = cnt_reg + 14'd1;
            end
         end

         DATA: begin
            if (bit_done) begin
               cnt_next  = '0;
               data_load = 1'b1;
               if (idx_reg == 3'd7) begin
                  idx_next   = '0;
                  state_next = STOP;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + 14'd1;
            end
         end

         STOP: begin
            if (bit_done) begin
               cnt_next   = '0;
               state_next = CLEANUP;
            end else begin
               cnt_next = cnt_reg + 14'd1;
            end
         end

         CLEANUP: begin
            cnt_next = '0;
            // Wait out a break: only a high line returns to IDLE.
            if (rx_s) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // Each shift-register bit only loads when its own index is sampled,
   // which places the first received bit in bit 0 (LSB first).
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shift
         assign shift_next[gi] = (data_load && (idx_reg == 3'(gi))) ? rx_s
                                                                   : shift_reg[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Process 3: next values of the registered outputs. The pulses default
   // low every cycle, so each lasts exactly one cycle; a full frame
   // separates any two of them.
   // ------------------------------------------------------------------
   always_comb begin
      dv_next     = 1'b0;
      err_next    = 1'b0;
      active_next = active_reg;
      byte_next   = byte_reg;

      case (state_reg)
         IDLE, DATA: begin
         end

         START: begin
            if (half_done && !rx_s) begin
               active_next = 1'b1;
            end
         end

         STOP: begin
            if (bit_done) begin
               if (rx_s) begin
                  dv_next   = 1'b1;
                  byte_next = shift_reg;
               end else begin
                  // Bad stop bit: report it, keep the previous good byte.
                  err_next = 1'b1;
               end
            end
         end

         CLEANUP: begin
            if (rx_s) begin
               active_next = 1'b0;
            end
         end

         default: begin
            active_next = 1'b0;
         end
      endcase
   end

   assign o_Rx_DV     = dv_reg;
   assign o_Frame_Err = err_reg;
   assign o_Rx_Active = active_reg;
   assign o_Rx_Byte   = byte_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_uart_rx -- two receivers (16 and 5 clocks per bit) driven by a serial
// transmitter model. For every frame sent the bench predicts, from the bit
// timing alone, the cycle of the o_Rx_DV / o_Frame_Err pulse, the byte and
// the o_Rx_Active window; a compare process checks all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB0 = 16;
   localparam int CPB1 = 5;
   localparam int MAPN = 32768;

   logic       clk = 1'b0;
   logic       rst;
   logic       line0, line1;
   logic       dv0, err0, act0, dv1, err1, act1;
   logic [7:0] byte0, byte1;

   uart_rx #(.CLKS_PER_BIT(CPB0)) dut0 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line0),
      .o_Rx_DV(dv0), .o_Rx_Byte(byte0), .o_Rx_Active(act0), .o_Frame_Err(err0)
   );

   uart_rx #(.CLKS_PER_BIT(CPB1)) dut1 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line1),
      .o_Rx_DV(dv1), .o_Rx_Byte(byte1), .o_Rx_Active(act1), .o_Frame_Err(err1)
   );

   always #5 clk = ~clk;

   // cyc equals the number of the most recent rising edge.
   int   cyc = 0;
   logic rst_seen = 1'b0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   typedef struct {
      int         d;
      int         at;
      bit         is_err;
      logic [7:0] b;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rx_log0[$];
   logic [7:0] exp_byte[2];
   bit         act_map0[MAPN];
   bit         act_map1[MAPN];
   int         dv_cnt[2];
   int         err_cnt[2];
   int         last_dv_cyc[2];
   bit         prev_pulse[2];
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic note_fail(input string name, input int got, input int want);
      total++;
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
   endtask

   function automatic logic get_dv(input int d);
      return (d == 0) ? dv0 : dv1;
   endfunction
   function automatic logic get_err(input int d);
      return (d == 0) ? err0 : err1;
   endfunction
   function automatic logic get_act(input int d);
      return (d == 0) ? act0 : act1;
   endfunction
   function automatic logic [7:0] get_byte(input int d);
      return (d == 0) ? byte0 : byte1;
   endfunction

   // ------------------------------------------------------------------
   // Compare process: every cycle, both receivers against the model.
   // ------------------------------------------------------------------
   always @(negedge clk) begin : cmp
      logic       p_dv, p_err, p_act;
      logic [7:0] p_byte;
      bit         a_exp;
      if (cyc >= 1) begin
         if (rst_seen) begin
            exp_byte[0] = 8'h00;
            exp_byte[1] = 8'h00;
            exp_q.delete();
         end
         for (int d = 0; d < 2; d++) begin
            p_dv   = get_dv(d);
            p_err  = get_err(d);
            p_act  = get_act(d);
            p_byte = get_byte(d);
            if (p_dv && p_err) note_fail("dv_and_err_together", 1, 0);
            if (p_dv || p_err) begin
               if (prev_pulse[d]) note_fail("pulse_in_consecutive_cycles", 1, 0);
               if (exp_q.size() > 0 && exp_q[0].d == d && exp_q[0].at == cyc) begin
                  chk($sformatf("pulse_kind_err_dut%0d", d), 32'(p_err), 32'(exp_q[0].is_err));
                  if (!exp_q[0].is_err) exp_byte[d] = exp_q[0].b;
                  void'(exp_q.pop_front());
               end else begin
                  note_fail($sformatf("unexpected_pulse_dut%0d", d), 1, 0);
               end
               if (p_dv) begin
                  dv_cnt[d]++;
                  last_dv_cyc[d] = cyc;
                  if (d == 0) rx_log0.push_back(p_byte);
               end
               if (p_err) err_cnt[d]++;
            end
            prev_pulse[d] = p_dv || p_err;
            chk($sformatf("rx_byte_dut%0d", d), 32'(p_byte), 32'(exp_byte[d]));
            a_exp = 1'b0;
            if (cyc < MAPN) a_exp = (d == 0) ? act_map0[cyc] : act_map1[cyc];
            chk($sformatf("rx_active_dut%0d", d), 32'(p_act), 32'(a_exp));
         end
         while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            note_fail($sformatf("missing_pulse_dut%0d_at_%0d", exp_q[0].d, exp_q[0].at), 0, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmitter model and expectation scheduling.
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_line(input int d, input logic v);
      if (d == 0) line0 = v;
      else line1 = v;
   endtask

   task automatic hold(input int d, input logic v, input int n);
      set_line(d, v);
      repeat (n) tick();
   endtask

   task automatic mark_act(input int d, input int a, input int b);
      for (int c = a; c <= b; c++) begin
         if (c >= 0 && c < MAPN) begin
            if (d == 0) act_map0[c] = 1'b1;
            else act_map1[c] = 1'b1;
         end
      end
   endtask

   // A line change made just after edge k reaches rx_s two edges later and
   // is seen in IDLE at edge k+3; the start check is HALF+1 edges after
   // that, each later sample one bit period apart, and the output pulse is
   // visible right after the stop-sample edge.
   task automatic send_frame(input int d, input int cpb, input logic [7:0] b,
                             input logic stop, input int hold_bits, input int gap,
                             input int abort_bit, output int k_out);
      int k, cs, t, half, h, r;
      half  = (cpb - 1) / 2;
      k     = cyc;
      cs    = k + 4 + half;
      t     = cs + 9 * cpb;
      k_out = k;
      if (abort_bit < 8) begin
         r = k + (1 + abort_bit) * cpb + cpb / 2;
         mark_act(d, cs, r);
         hold(d, 1'b0, cpb);
         for (int i = 0; i < abort_bit; i++) hold(d, b[i], cpb);
         hold(d, b[abort_bit], cpb / 2);
         rst = 1'b1;
         set_line(d, 1'b1);
         tick();
         rst = 1'b0;
         chk("reset_midframe_dv", 32'(get_dv(d)), 32'd0);
         chk("reset_midframe_err", 32'(get_err(d)), 32'd0);
         chk("reset_midframe_active", 32'(get_act(d)), 32'd0);
         chk("reset_midframe_byte", 32'(get_byte(d)), 32'h00);
         hold(d, 1'b1, gap);
      end else begin
         if (stop) begin
            exp_q.push_back('{d, t, 1'b0, b});
            mark_act(d, cs, t);
         end else begin
            h = k + 10 * cpb + hold_bits * cpb;
            exp_q.push_back('{d, t, 1'b1, b});
            mark_act(d, cs, h + 2);
         end
         hold(d, 1'b0, cpb);
         for (int i = 0; i < 8; i++) hold(d, b[i], cpb);
         hold(d, stop, cpb);
         if (!stop) hold(d, 1'b0, hold_bits * cpb);
         hold(d, 1'b1, gap);
      end
   endtask

   task automatic glitch(input int d, input int len, input int gap);
      hold(d, 1'b0, len);
      hold(d, 1'b1, gap);
   endtask

   task automatic random_traffic(input int d, input int cpb, input int n);
      int         k, sel, hb, gp;
      logic [7:0] b;
      logic       stp;
      for (int i = 0; i < n; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 15) begin
            glitch(d, int'($urandom_range(1, (cpb - 1) / 2)), cpb + int'($urandom_range(0, 10)));
         end else begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 99) < 80);
            hb  = stp ? 0 : int'($urandom_range(0, 2));
            gp  = stp ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            send_frame(d, cpb, b, stp, hb, gp, 8, k);
         end
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int k;
      rst         = 1'b1;
      line0       = 1'b1;
      line1       = 1'b1;
      exp_byte[0] = 8'h00;
      exp_byte[1] = 8'h00;
      repeat (3) tick();
      chk("reset_dv", 32'(dv0), 32'd0);
      chk("reset_err", 32'(err0), 32'd0);
      chk("reset_active", 32'(act0), 32'd0);
      chk("reset_byte", 32'(byte0), 32'h00);
      rst = 1'b0;
      repeat (10) tick();

      // Single good frame; latency = 4 + 7 + 9*16 = 155 edges after launch.
      send_frame(0, CPB0, 8'hA5, 1'b1, 0, 20, 8, k);
      chk("a5_byte", 32'(byte0), 32'hA5);
      chk("a5_latency", 32'(last_dv_cyc[0] - k), 32'd155);
      chk("a5_dv_count", 32'(dv_cnt[0]), 32'd1);
      chk("a5_err_count", 32'(err_cnt[0]), 32'd0);
      chk("a5_active_after", 32'(act0), 32'd0);

      // Back-to-back frames, no idle gap.
      send_frame(0, CPB0, 8'h00, 1'b1, 0, 0, 8, k);
      send_frame(0, CPB0, 8'hFF, 1'b1, 0, 0, 8, k);
      send_frame(0, CPB0, 8'h3C, 1'b1, 0, 20, 8, k);
      chk("b2b_dv_count", 32'(dv_cnt[0]), 32'd4);
      chk("b2b_first", 32'(rx_log0[1]), 32'h00);
      chk("b2b_second", 32'(rx_log0[2]), 32'hFF);
      chk("b2b_third", 32'(rx_log0[3]), 32'h3C);

      // Five-cycle low glitch on an idle line.
      glitch(0, 5, 40);
      chk("glitch_dv_count", 32'(dv_cnt[0]), 32'd4);
      chk("glitch_active", 32'(act0), 32'd0);

      // Bad stop bit followed by a break, then a good frame.
      send_frame(0, CPB0, 8'h5A, 1'b0, 3, 20, 8, k);
      chk("ferr_count", 32'(err_cnt[0]), 32'd1);
      chk("ferr_byte_kept", 32'(byte0), 32'h3C);
      chk("ferr_no_dv", 32'(dv_cnt[0]), 32'd4);
      send_frame(0, CPB0, 8'h81, 1'b1, 0, 20, 8, k);
      chk("after_ferr_byte", 32'(byte0), 32'h81);
      chk("after_ferr_dv_count", 32'(dv_cnt[0]), 32'd5);

      // Reset during bit 4 of 8'hC3, then a normal frame.
      send_frame(0, CPB0, 8'hC3, 1'b1, 0, 30, 4, k);
      chk("aborted_no_dv", 32'(dv_cnt[0]), 32'd5);
      chk("aborted_no_err", 32'(err_cnt[0]), 32'd1);
      send_frame(0, CPB0, 8'h42, 1'b1, 0, 20, 8, k);
      chk("after_reset_byte", 32'(byte0), 32'h42);

      random_traffic(0, CPB0, 30);

      // Short bit period: latency = 4 + 2 + 9*5 = 51 edges after launch.
      send_frame(1, CPB1, 8'h7E, 1'b1, 0, 10, 8, k);
      chk("cpb5_byte", 32'(byte1), 32'h7E);
      chk("cpb5_latency", 32'(last_dv_cyc[1] - k), 32'd51);
      random_traffic(1, CPB1, 30);

      repeat (20) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
